f1_fetch_issue: RTL

F1_FETCH_ISSUE -- requirements
Module: f1_fetch_issue

---
 rtl/f1_fetch_issue_pkg.sv | 26 ++
 rtl/f1_fetch_issue_dff.sv | 20 ++
 rtl/f1_fetch_issue.sv | 126 ++++++++++++
 3 files changed

// File: rtl/f1_fetch_issue_pkg.sv
// rtl/f1_fetch_issue_pkg.sv - shared core types and constants for the F1 fetch-issue stage
package f1_fetch_issue_pkg;

  typedef enum logic [2:0] {
    F1_BOOT      = 3'd0,
    F1_RUN       = 3'd1,
    F1_CACHEOP   = 3'd2,
    F1_WAIT_DONE = 3'd3,
    F1_RESTART   = 3'd4,
    F1_EXC_HALT  = 3'd5
  } f1_state_e;

  localparam logic [4:0]  F1_EXC_ADEL     = 5'd4;
  localparam logic [4:0]  F1_EXC_NONE     = 5'd0;
  localparam logic [31:0] F1_RESET_VECTOR = 32'hBFC0_0000;

  // States that present a fetch slot to F2 (before any redirect squash).
  function automatic logic f1_state_issues(input f1_state_e s);
    return (s == F1_RUN) || (s == F1_CACHEOP) || (s == F1_RESTART);
  endfunction

  function automatic logic f1_state_busy(input f1_state_e s);
    return (s == F1_CACHEOP) || (s == F1_WAIT_DONE) || (s == F1_RESTART);
  endfunction

endpackage

// File: rtl/f1_fetch_issue_dff.sv
// rtl/f1_fetch_issue_dff.sv - D flip-flop primitive with asynchronous active-low reset
module f1_fetch_issue_dff #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q <= RESET_VALUE;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/f1_fetch_issue.sv
// rtl/f1_fetch_issue.sv - F1 fetch-slot issue FSM with I-cache maintenance sequencing
module f1_fetch_issue
  import f1_fetch_issue_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = F1_RESET_VECTOR
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        F2_Stall,
  input  logic        Redirect_Valid,
  input  logic [31:0] Redirect_PC,
  input  logic        ICacheOp_Req,
  input  logic [31:0] ICacheOp_PC,
  input  logic [31:0] XOP_ResumePC,
  input  logic        ICacheOp_Done,
  output logic        F1_Issued,
  output logic [31:0] F1_PC,
  output logic [31:0] F1_PCAdd4,
  output logic        F1_Exception,
  output logic [4:0]  F1_ExcCode,
  output logic        F1_DoICacheOp,
  output logic        F1_XOP_Restart,
  output logic        ICacheOp_Busy
);

  f1_state_e   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] resume_q, resume_d;
  logic [31:0] pc_add4;
  logic        redirect;
  logic        issued;
  logic        do_op;
  logic        xop_restart;
  logic        exception;
  logic        accept;

  always_comb begin
    pc_add4     = pc_q + 32'd4;
    // A cache op in flight cannot be abandoned by a redirect.
    redirect    = Redirect_Valid && (state_q != F1_WAIT_DONE);
    issued      = f1_state_issues(state_q) && !redirect;
    do_op       = issued && (state_q == F1_CACHEOP);
    xop_restart = issued && (state_q == F1_RESTART);
    exception   = issued && (pc_q[1:0] != 2'b00) && !do_op;
    accept      = issued && !F2_Stall;
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    resume_d = resume_q;
    if (redirect) begin
      pc_d    = Redirect_PC;
      state_d = F1_RUN;
    end else begin
      case (state_q)
        F1_BOOT: state_d = F1_RUN;
        F1_RUN: begin
          if (ICacheOp_Req) begin
            pc_d     = ICacheOp_PC;
            resume_d = XOP_ResumePC;
            state_d  = F1_CACHEOP;
          end else if (accept) begin
            pc_d    = pc_add4;
            state_d = exception ? F1_EXC_HALT : F1_RUN;
          end
        end
        F1_CACHEOP: begin
          if (accept) state_d = F1_WAIT_DONE;
        end
        F1_WAIT_DONE: begin
          if (ICacheOp_Done) begin
            pc_d    = resume_q;
            state_d = F1_RESTART;
          end
        end
        F1_RESTART: begin
          if (accept) begin
            pc_d    = pc_add4;
            state_d = exception ? F1_EXC_HALT : F1_RUN;
          end
        end
        F1_EXC_HALT: state_d = F1_EXC_HALT;
        default:     state_d = F1_BOOT;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= F1_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  f1_fetch_issue_dff #(
    .WIDTH       (32),
    .RESET_VALUE (RESET_VECTOR)
  ) u_pc_dff (
    .clock (clock),
    .reset (reset),
    .d     (pc_d),
    .q     (pc_q)
  );

  f1_fetch_issue_dff #(
    .WIDTH       (32),
    .RESET_VALUE (32'h0000_0000)
  ) u_resume_dff (
    .clock (clock),
    .reset (reset),
    .d     (resume_d),
    .q     (resume_q)
  );

  assign F1_Issued      = issued;
  assign F1_PC          = pc_q;
  assign F1_PCAdd4      = pc_add4;
  assign F1_Exception   = exception;
  assign F1_ExcCode     = exception ? F1_EXC_ADEL : F1_EXC_NONE;
  assign F1_DoICacheOp  = do_op;
  assign F1_XOP_Restart = xop_restart;
  assign ICacheOp_Busy  = f1_state_busy(state_q);

endmodule
